// File: rtl/dsp_pkg.sv
// Shared definitions for dsp_seq: operand modes, issue counts and sequencer states.
package dsp_pkg;

    typedef enum logic [1:0] {
        MODE_HH  = 2'd0,
        MODE_FH  = 2'd1,
        MODE_FF  = 2'd2,
        MODE_BAD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    // Issue count minus one; the unsupported mode falls back to half x half.
    function automatic logic [1:0] issue_last(input logic [1:0] mode);
        case (mode)
            2'(MODE_FH): return 2'd1;
            2'(MODE_FF): return 2'd3;
            default:     return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/dsp_seq.sv
// Request/response sequencer driving a multi-cycle DSP multiplier.
// Optional: define DSP_SEQ_OPCNT_EN to add a 16-bit response counter port op_count.
module dsp_seq
    import dsp_pkg::*;
#(
    parameter int N   = 16,
    parameter int M   = 16,
    parameter int LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N-1:0]     req_a,
    input  logic [M-1:0]     req_b,
    input  logic [N+M-1:0]   req_c,
    input  logic [1:0]       req_mode,
    input  logic             req_mac,
    input  logic [1:0]       req_shift,
    output logic             dsp_start,
    output logic [N-1:0]     dsp_aa,
    output logic [M-1:0]     dsp_bb,
    output logic [N+M-1:0]   dsp_cc,
    output logic [1:0]       dsp_mode,
    output logic             dsp_mac,
    output logic             dsp_mac_start,
    output logic [1:0]       dsp_barrel_shifter,
    input  logic [N+M-1:0]   dsp_out,
`ifdef DSP_SEQ_OPCNT_EN
    output logic [15:0]      op_count,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N+M-1:0]   rsp_data,
    output logic             rsp_mode_err
);

    localparam logic [1:0] DRAIN_LAST = 2'((LAT > 0) ? LAT - 1 : 0);

    state_e     state, state_n;
    logic [1:0] cnt, cnt_n;
    logic       accept, capture, err_q;

    // req_ready is masked by reset so nothing is offered while reset is held.
    assign req_ready    = (state == S_IDLE) && !reset;
    assign accept       = req_valid && req_ready;
    assign rsp_valid    = (state == S_HOLD);
    assign rsp_mode_err = rsp_valid && err_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_ISSUE;
                    cnt_n   = issue_last(req_mode);
                end
            end
            S_ISSUE: begin
                if (cnt != 2'd0) begin
                    cnt_n = cnt - 2'd1;
                end else if (LAT == 0) begin
                    capture = 1'b1;
                    state_n = S_HOLD;
                end else begin
                    state_n = S_DRAIN;
                    cnt_n   = DRAIN_LAST;
                end
            end
            S_DRAIN: begin
                if (cnt != 2'd0) begin
                    cnt_n = cnt - 2'd1;
                end else begin
                    capture = 1'b1;
                    state_n = S_HOLD;
                end
            end
            S_HOLD: begin
                if (rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Operand registers stay loaded after the response; mac/shift state persists into IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dsp_start          <= 1'b0;
            dsp_mac_start      <= 1'b0;
            dsp_aa             <= '0;
            dsp_bb             <= '0;
            dsp_cc             <= '0;
            dsp_mode           <= 2'd0;
            dsp_mac            <= 1'b0;
            dsp_barrel_shifter <= 2'd0;
            err_q              <= 1'b0;
            rsp_data           <= '0;
        end else begin
            dsp_start     <= accept;
            dsp_mac_start <= accept && req_mac && !dsp_mac;
            if (accept) begin
                dsp_aa             <= req_a;
                dsp_bb             <= req_b;
                dsp_cc             <= req_c;
                dsp_mode           <= (req_mode == 2'(MODE_BAD)) ? 2'(MODE_HH) : req_mode;
                dsp_mac            <= req_mac;
                dsp_barrel_shifter <= req_shift;
                err_q              <= (req_mode == 2'(MODE_BAD));
            end
            if (capture) rsp_data <= dsp_out;
        end
    end

`ifdef DSP_SEQ_OPCNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       op_count <= 16'd0;
        else if (rsp_valid && rsp_ready) op_count <= op_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_dsp_seq.sv
// Directed bench for dsp_seq with a behavioural DSP that presents its result only in the sample cycle.
module tb_dsp_seq;
    localparam int N   = 16;
    localparam int M   = 16;
    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [15:0] req_a = '0, req_b = '0;
    logic [31:0] req_c = '0;
    logic [1:0]  req_mode = '0, req_shift = '0;
    logic        req_mac = 1'b0;
    logic        dsp_start, dsp_mac, dsp_mac_start;
    logic [15:0] dsp_aa, dsp_bb;
    logic [31:0] dsp_cc, dsp_out;
    logic [1:0]  dsp_mode, dsp_barrel_shifter;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_mode_err;
    logic [31:0] rsp_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dsp_seq #(.N(N), .M(M), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .req_mode(req_mode), .req_mac(req_mac), .req_shift(req_shift),
        .dsp_start(dsp_start), .dsp_aa(dsp_aa), .dsp_bb(dsp_bb), .dsp_cc(dsp_cc),
        .dsp_mode(dsp_mode), .dsp_mac(dsp_mac), .dsp_mac_start(dsp_mac_start),
        .dsp_barrel_shifter(dsp_barrel_shifter), .dsp_out(dsp_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_mode_err(rsp_mode_err)
    );

    // DSP model: result computed from operands seen with dsp_start, visible only K+LAT-1 cycles later.
    logic [31:0] m_prod, m_new, m_acc, m_res;
    logic [3:0]  m_e, m_need, m_k;
    logic        m_busy;

    always_comb begin
        case (dsp_mode)
            2'd0:    begin m_prod = {24'd0, dsp_aa[7:0]} * {24'd0, dsp_bb[7:0]}; m_k = 4'd1; end
            2'd1:    begin m_prod = {16'd0, dsp_aa} * {24'd0, dsp_bb[7:0]};      m_k = 4'd2; end
            2'd2:    begin m_prod = {16'd0, dsp_aa} * {16'd0, dsp_bb};           m_k = 4'd4; end
            default: begin m_prod = 32'hEEEE_EEEE;                               m_k = 4'd1; end
        endcase
        if (dsp_mac) m_new = (dsp_mac_start ? 32'd0 : (m_acc >> dsp_barrel_shifter)) + m_prod;
        else         m_new = m_prod + dsp_cc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_e <= '0; m_need <= '0; m_acc <= '0; m_res <= '0;
        end else if (dsp_start) begin
            m_busy <= 1'b1;
            m_e    <= 4'd1;
            m_need <= m_k + 4'(LAT) - 4'd1;
            m_res  <= m_new;
            if (dsp_mac) m_acc <= m_new;
        end else if (m_busy) begin
            m_e <= m_e + 4'd1;
            if (m_e >= m_need) m_busy <= 1'b0;
        end
    end

    assign dsp_out = (m_busy && m_e == m_need) ? m_res : 32'hBAD0_BAD0;

    // Drive one request while IDLE; returns just after the accepting edge (cycle 0 ends there).
    task automatic drive_req(input logic [15:0] a, input logic [15:0] b, input logic [31:0] c,
                             input logic [1:0] mode, input logic mac, input logic [1:0] sh);
        req_a = a; req_b = b; req_c = c; req_mode = mode; req_mac = mac; req_shift = sh;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", req_ready); end
        total++;
        if ({rsp_valid, rsp_mode_err, dsp_start, dsp_mac, dsp_mac_start, rsp_data, dsp_aa, dsp_mode} !== '0) begin
            bad++; $display("FAIL reset_outputs got v=%b d=%h start=%b mac=%b", rsp_valid, rsp_data, dsp_start, dsp_mac);
        end
    endtask

    task automatic test_mode2;
        rsp_ready = 1'b0;
        @(negedge clk);
        drive_req(16'h1234, 16'h5678, 32'd0, 2'd2, 1'b0, 2'd0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            total++;
            if (dsp_start !== (i == 1) || req_ready !== 1'b0 || rsp_valid !== (i >= 6)) begin
                bad++; $display("FAIL mode2_timing cycle %0d: start=%b ready=%b valid=%b", i, dsp_start, req_ready, rsp_valid);
            end
            if (i <= 4) begin
                total++;
                if (dsp_aa !== 16'h1234 || dsp_bb !== 16'h5678 || dsp_mode !== 2'd2) begin
                    bad++; $display("FAIL mode2_operands cycle %0d: aa=%h bb=%h mode=%0d", i, dsp_aa, dsp_bb, dsp_mode);
                end
            end
            if (i >= 6) begin
                total++;
                if (rsp_data !== 32'h0626_0060) begin bad++; $display("FAIL mode2_data cycle %0d: got %h want 06260060", i, rsp_data); end
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL mode2_release: valid=%b ready=%b want 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_mode0;
        rsp_ready = 1'b1;
        drive_req(16'd3, 16'd4, 32'd0, 2'd0, 1'b0, 2'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            total++;
            if (dsp_start !== (i == 1) || req_ready !== (i == 4) || rsp_valid !== (i == 3)) begin
                bad++; $display("FAIL mode0_timing cycle %0d: start=%b ready=%b valid=%b", i, dsp_start, req_ready, rsp_valid);
            end
            if (i == 3) begin
                total++;
                if (rsp_data !== 32'd12 || rsp_mode_err !== 1'b0) begin
                    bad++; $display("FAIL mode0_data: got %0d err=%b want 12 err=0", rsp_data, rsp_mode_err);
                end
            end
        end
    endtask

    // Two full x half requests accepted at the minimum spacing of K+LAT+2 = 5 cycles.
    task automatic test_back_to_back;
        logic [15:0] av [2];
        logic [15:0] bv [2];
        logic [31:0] cv [2];
        logic [31:0] ev [2];
        av = '{16'h1000, 16'h0022}; bv = '{16'hAB03, 16'h0010};
        cv = '{32'd0, 32'd1};       ev = '{32'h3000, 32'h221};
        rsp_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            drive_req(av[n], bv[n], cv[n], 2'd1, 1'b0, 2'd0);
            for (int i = 1; i <= 5; i++) begin
                @(negedge clk);
                total++;
                if (dsp_start !== (i == 1) || req_ready !== (i == 5) || rsp_valid !== (i == 4)) begin
                    bad++; $display("FAIL b2b_timing req %0d cycle %0d: start=%b ready=%b valid=%b", n, i, dsp_start, req_ready, rsp_valid);
                end
                if (i == 4) begin
                    total++;
                    if (rsp_data !== ev[n]) begin bad++; $display("FAIL b2b_data req %0d: got %h want %h", n, rsp_data, ev[n]); end
                end
            end
        end
    endtask

    task automatic test_mac;
        logic [31:0] ev [4];
        logic        ms [4];
        logic [1:0]  sv [4];
        ev = '{32'd12, 32'd24, 32'd36, 32'd30};
        ms = '{1'b1, 1'b0, 1'b0, 1'b0};
        sv = '{2'd0, 2'd0, 2'd0, 2'd1};
        rsp_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            drive_req(16'd3, 16'd4, 32'd0, 2'd0, 1'b1, sv[n]);
            for (int i = 1; i <= 4; i++) begin
                @(negedge clk);
                if (i == 1) begin
                    total++;
                    if (dsp_mac_start !== ms[n] || dsp_mac !== 1'b1 || dsp_barrel_shifter !== sv[n]) begin
                        bad++; $display("FAIL mac_ctrl req %0d: mac_start=%b mac=%b sh=%0d want %b 1 %0d", n, dsp_mac_start, dsp_mac, dsp_barrel_shifter, ms[n], sv[n]);
                    end
                end else begin
                    total++;
                    if (dsp_mac_start !== 1'b0) begin bad++; $display("FAIL mac_pulse req %0d cycle %0d: got %b want 0", n, i, dsp_mac_start); end
                end
                if (i == 3) begin
                    total++;
                    if (rsp_data !== ev[n]) begin bad++; $display("FAIL mac_data req %0d: got %0d want %0d", n, rsp_data, ev[n]); end
                end
            end
        end
    endtask

    task automatic test_mode_err;
        logic [1:0]  md [2];
        logic [31:0] ev [2];
        md = '{2'd3, 2'd0};
        ev = '{32'd30, 32'd30};
        rsp_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            drive_req(16'd5, 16'd6, 32'd0, md[n], 1'b0, 2'd0);
            for (int i = 1; i <= 4; i++) begin
                @(negedge clk);
                total++;
                if (rsp_valid !== (i == 3) || rsp_mode_err !== (i == 3 && n == 0)) begin
                    bad++; $display("FAIL moderr_timing req %0d cycle %0d: valid=%b err=%b", n, i, rsp_valid, rsp_mode_err);
                end
                if (i == 1) begin
                    total++;
                    if (dsp_mode !== 2'd0 || dsp_mac !== 1'b0) begin bad++; $display("FAIL moderr_issue req %0d: mode=%0d mac=%b want 0 0", n, dsp_mode, dsp_mac); end
                end
                if (i == 3) begin
                    total++;
                    if (rsp_data !== ev[n]) begin bad++; $display("FAIL moderr_data req %0d: got %0d want %0d", n, rsp_data, ev[n]); end
                end
            end
        end
    endtask

    task automatic test_hold_and_reset;
        rsp_ready = 1'b0;
        drive_req(16'd7, 16'd8, 32'd0, 2'd0, 1'b0, 2'd0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'd56 || req_ready !== 1'b0) begin
                bad++; $display("FAIL hold_stable step %0d: valid=%b data=%0d want 1 56", i, rsp_valid, rsp_data);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        drive_req(16'hFFFF, 16'hFFFF, 32'h5, 2'd2, 1'b1, 2'd3);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if ({rsp_valid, rsp_mode_err, dsp_start, dsp_mac, dsp_mac_start, dsp_barrel_shifter,
             dsp_mode, dsp_aa, dsp_bb, dsp_cc, rsp_data} !== '0) begin
            bad++; $display("FAIL midreset_outputs: aa=%h mode=%0d mac=%b sh=%0d valid=%b want all 0", dsp_aa, dsp_mode, dsp_mac, dsp_barrel_shifter, rsp_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got %b want 1", req_ready); end
        drive_req(16'd3, 16'd4, 32'd0, 2'd0, 1'b1, 2'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) begin
                total++;
                if (dsp_mac_start !== 1'b1 || dsp_start !== 1'b1) begin
                    bad++; $display("FAIL postreset_mac_start got %b start=%b want 1 1", dsp_mac_start, dsp_start);
                end
            end
            if (i == 3) begin
                total++;
                if (rsp_valid !== 1'b1 || rsp_data !== 32'd12) begin
                    bad++; $display("FAIL postreset_data valid=%b got %0d want 1 12", rsp_valid, rsp_data);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode2();
        test_mode0();
        test_back_to_back();
        test_mac();
        test_mode_err();
        test_hold_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
